// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg : shared types and helpers for the countdown timer controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } t_tmr_state;

  typedef logic [7:0] t_bcd2;

  localparam t_bcd2 BCD_ZERO = 8'h00;

  function automatic logic bcd2_valid(input t_bcd2 value, input logic [3:0] tens_max);
    return (value[7:4] <= tens_max) && (value[3:0] <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mmss_dec.sv
// ---------------------------------------------------------------------------
// bcd_mmss_dec : combinational MM:SS BCD decrement with borrow and zero flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_mmss_dec
  import countdown_pkg::*;
(
  input  t_bcd2 i_min,
  input  t_bcd2 i_sec,
  output t_bcd2 o_min,
  output t_bcd2 o_sec,
  output logic  o_borrow,
  output logic  o_zero
);

  always_comb begin
    o_min    = i_min;
    o_sec    = i_sec;
    o_borrow = 1'b0;
    if (i_sec[3:0] != 4'd0) begin
      o_sec[3:0] = i_sec[3:0] - 4'd1;
    end else if (i_sec[7:4] != 4'd0) begin
      o_sec = {i_sec[7:4] - 4'd1, 4'd9};
    end else begin
      // seconds wrap 00 -> 59 and borrow a minute
      o_sec    = 8'h59;
      o_borrow = 1'b1;
      if (i_min[3:0] != 4'd0)
        o_min[3:0] = i_min[3:0] - 4'd1;
      else if (i_min[7:4] != 4'd0)
        o_min = {i_min[7:4] - 4'd1, 4'd9};
      else
        o_min = 8'h99;
    end
    o_zero = (o_min == BCD_ZERO) && (o_sec == BCD_ZERO);
  end

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_ctrl : countdown-timer FSM driving the tick divider and alarm
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int p_alarm_ticks = 10,
  parameter int p_max_min     = 99
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_set_min,
  input  logic [7:0] i_set_sec,
  output logic       o_div_stop,
  output logic       o_div_rst,
  output logic [7:0] o_min,
  output logic [7:0] o_sec,
  output logic [1:0] o_state,
  output logic       o_alarm,
  output logic       o_err
);

  localparam int                  c_acnt_w     = $clog2(p_alarm_ticks + 1);
  localparam logic [c_acnt_w-1:0] c_alarm_max  = c_acnt_w'(p_alarm_ticks);
  localparam logic [c_acnt_w-1:0] c_alarm_last = c_acnt_w'(p_alarm_ticks - 1);
  localparam logic [7:0]          c_max_min    = 8'(p_max_min);

  t_tmr_state          r_state;
  t_bcd2               r_min, r_sec;
  logic                r_div_stop, r_div_rst, r_alarm, r_err;
  logic [c_acnt_w-1:0] r_alarm_cnt;

  t_bcd2      w_dec_min, w_dec_sec;
  logic       w_dec_borrow, w_dec_zero;
  logic [7:0] w_set_min_bin;
  logic       w_load_ok, w_count_zero;

  bcd_mmss_dec u_dec (
    .i_min    (r_min),
    .i_sec    (r_sec),
    .o_min    (w_dec_min),
    .o_sec    (w_dec_sec),
    .o_borrow (w_dec_borrow),
    .o_zero   (w_dec_zero)
  );

  assign w_set_min_bin = ({4'd0, i_set_min[7:4]} * 8'd10) + {4'd0, i_set_min[3:0]};
  assign w_load_ok     = bcd2_valid(i_set_sec, 4'd5) && bcd2_valid(i_set_min, 4'd9) &&
                         (w_set_min_bin <= c_max_min);
  assign w_count_zero  = (r_min == BCD_ZERO) && (r_sec == BCD_ZERO);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_min       <= BCD_ZERO;
      r_sec       <= BCD_ZERO;
      r_div_stop  <= 1'b1;
      r_div_rst   <= 1'b1;
      r_alarm     <= 1'b0;
      r_err       <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_div_rst <= 1'b0;
      r_err     <= 1'b0;
      if (i_clear) begin
        r_state     <= ST_IDLE;
        r_min       <= BCD_ZERO;
        r_sec       <= BCD_ZERO;
        r_div_stop  <= 1'b1;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_load) begin
              if (w_load_ok) begin
                r_min <= i_set_min;
                r_sec <= i_set_sec;
              end else begin
                r_err <= 1'b1;
              end
            end else if (i_start && !w_count_zero) begin
              // one-cycle divider reset aligns the tick phase to the start
              r_state    <= ST_RUN;
              r_div_stop <= 1'b0;
              r_div_rst  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (i_tick) begin
              r_sec <= w_dec_sec;
              if (w_dec_borrow) r_min <= w_dec_min;
            end
            if (i_tick && w_dec_zero) begin
              r_state     <= ST_EXPIRED;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= '0;
            end else if (i_pause && !i_load && !i_start) begin
              r_state    <= ST_PAUSE;
              r_div_stop <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (i_load) begin
              if (w_load_ok) begin
                r_min   <= i_set_min;
                r_sec   <= i_set_sec;
                r_state <= ST_IDLE;
              end else begin
                r_err <= 1'b1;
              end
            end else if (i_start) begin
              r_state    <= ST_RUN;
              r_div_stop <= 1'b0;
            end
          end
          default: begin
            if (i_load) begin
              if (w_load_ok) begin
                r_min       <= i_set_min;
                r_sec       <= i_set_sec;
                r_state     <= ST_IDLE;
                r_div_stop  <= 1'b1;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
              end else begin
                r_err <= 1'b1;
              end
            end else if (i_tick) begin
              if (r_alarm_cnt == c_alarm_last) begin
                r_state     <= ST_IDLE;
                r_div_stop  <= 1'b1;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
              end else if (r_alarm_cnt != c_alarm_max) begin
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_state    = r_state;
  assign o_min      = r_min;
  assign o_sec      = r_sec;
  assign o_div_stop = r_div_stop;
  assign o_div_rst  = r_div_rst;
  assign o_alarm    = r_alarm;
  assign o_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_ctrl : directed self-checking bench for countdown_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_countdown_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_tick = 1'b0, i_start = 1'b0, i_pause = 1'b0, i_clear = 1'b0, i_load = 1'b0;
  logic [7:0] i_set_min = 8'h00, i_set_sec = 8'h00;
  logic       o_div_stop, o_div_rst, o_alarm, o_err;
  logic [7:0] o_min, o_sec;
  logic [1:0] o_state;

  int tests = 0;
  int fails = 0;

  countdown_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_start    (i_start),
    .i_pause    (i_pause),
    .i_clear    (i_clear),
    .i_load     (i_load),
    .i_set_min  (i_set_min),
    .i_set_sec  (i_set_sec),
    .o_div_stop (o_div_stop),
    .o_div_rst  (o_div_rst),
    .o_min      (o_min),
    .o_sec      (o_sec),
    .o_state    (o_state),
    .o_alarm    (o_alarm),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of command pulses, return 1 time unit after the edge
  task automatic cmd(input logic t, input logic s, input logic p, input logic c, input logic l);
    i_tick = t; i_start = s; i_pause = p; i_clear = c; i_load = l;
    @(posedge i_clk); #1;
    i_tick = 0; i_start = 0; i_pause = 0; i_clear = 0; i_load = 0;
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] s);
    i_set_min = m; i_set_sec = s;
    cmd(0, 0, 0, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {6'd0, o_state}, 8'd0);
    chk({tag, "_min"}, o_min, 8'h00);
    chk({tag, "_sec"}, o_sec, 8'h00);
    chk({tag, "_stop"}, {7'd0, o_div_stop}, 8'd1);
    chk({tag, "_divrst"}, {7'd0, o_div_rst}, 8'd1);
    chk({tag, "_alarm"}, {7'd0, o_alarm}, 8'd0);
    chk({tag, "_err"}, {7'd0, o_err}, 8'd0);
  endtask

  initial begin
    // reset
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_vals("rst");
    i_rst = 1'b0;
    cmd(0, 0, 0, 0, 0);
    chk("rst_release_divrst", {7'd0, o_div_rst}, 8'd0);
    chk("rst_release_stop", {7'd0, o_div_stop}, 8'd1);

    // 1: load 01:05, start, tick down across the minute borrow
    load(8'h01, 8'h05);
    chk("t1_load_min", o_min, 8'h01);
    chk("t1_load_sec", o_sec, 8'h05);
    cmd(0, 1, 0, 0, 0);
    chk("t1_run", {6'd0, o_state}, 8'd1);
    chk("t1_divrst_hi", {7'd0, o_div_rst}, 8'd1);
    chk("t1_stop_lo", {7'd0, o_div_stop}, 8'd0);
    cmd(0, 0, 0, 0, 0);
    chk("t1_divrst_lo", {7'd0, o_div_rst}, 8'd0);
    for (int i = 0; i < 5; i++) cmd(1, 0, 0, 0, 0);
    chk("t1_5tick_min", o_min, 8'h01);
    chk("t1_5tick_sec", o_sec, 8'h00);
    cmd(1, 0, 0, 0, 0);
    chk("t1_6tick_min", o_min, 8'h00);
    chk("t1_6tick_sec", o_sec, 8'h59);
    load(8'h00, 8'h10);
    chk("t1_load_in_run_ignored", o_sec, 8'h59);

    // 2: expire and alarm window
    cmd(0, 0, 0, 1, 0);
    chk("t2_clear_state", {6'd0, o_state}, 8'd0);
    load(8'h00, 8'h02);
    cmd(0, 1, 0, 0, 0);
    cmd(1, 0, 0, 0, 0);
    chk("t2_one_left", o_sec, 8'h01);
    cmd(1, 0, 0, 0, 0);
    chk("t2_expired", {6'd0, o_state}, 8'd3);
    chk("t2_alarm_hi", {7'd0, o_alarm}, 8'd1);
    chk("t2_exp_stop", {7'd0, o_div_stop}, 8'd0);
    cmd(0, 1, 0, 0, 0);
    chk("t2_start_ignored", {6'd0, o_state}, 8'd3);
    for (int i = 0; i < 9; i++) cmd(1, 0, 0, 0, 0);
    chk("t2_9ticks_still_exp", {6'd0, o_state}, 8'd3);
    cmd(1, 0, 0, 0, 0);
    chk("t2_idle", {6'd0, o_state}, 8'd0);
    chk("t2_alarm_lo", {7'd0, o_alarm}, 8'd0);
    chk("t2_min", o_min, 8'h00);
    chk("t2_sec", o_sec, 8'h00);

    // 3: pause with coincident tick, in-flight tick ignored, resume
    load(8'h00, 8'h30);
    cmd(0, 1, 0, 0, 0);
    cmd(1, 0, 1, 0, 0);
    chk("t3_paused", {6'd0, o_state}, 8'd2);
    chk("t3_sec", o_sec, 8'h29);
    chk("t3_stop", {7'd0, o_div_stop}, 8'd1);
    cmd(1, 0, 0, 0, 0);
    chk("t3_held", o_sec, 8'h29);
    cmd(0, 1, 0, 0, 0);
    chk("t3_resume", {6'd0, o_state}, 8'd1);
    chk("t3_no_divrst", {7'd0, o_div_rst}, 8'd0);
    chk("t3_resume_stop", {7'd0, o_div_stop}, 8'd0);

    // 4: illegal loads
    cmd(0, 0, 0, 1, 0);
    load(8'h1A, 8'h70);
    chk("t4_err1", {7'd0, o_err}, 8'd1);
    chk("t4_min1", o_min, 8'h00);
    chk("t4_sec1", o_sec, 8'h00);
    cmd(0, 0, 0, 0, 0);
    chk("t4_err_pulse", {7'd0, o_err}, 8'd0);
    load(8'hA0, 8'h00);
    chk("t4_err2", {7'd0, o_err}, 8'd1);
    chk("t4_min2", o_min, 8'h00);
    cmd(0, 1, 0, 0, 0);
    chk("t4_start_zero", {6'd0, o_state}, 8'd0);
    chk("t4_start_zero_stop", {7'd0, o_div_stop}, 8'd1);

    // 5: clear beats load and start in RUN
    load(8'h00, 8'h30);
    cmd(0, 1, 0, 0, 0);
    i_set_min = 8'h05; i_set_sec = 8'h05;
    cmd(0, 1, 0, 1, 1);
    chk("t5_state", {6'd0, o_state}, 8'd0);
    chk("t5_min", o_min, 8'h00);
    chk("t5_sec", o_sec, 8'h00);
    chk("t5_stop", {7'd0, o_div_stop}, 8'd1);

    // 6: asynchronous reset mid-RUN
    load(8'h00, 8'h30);
    cmd(0, 1, 0, 0, 0);
    cmd(1, 0, 0, 0, 0);
    chk("t6_running", o_sec, 8'h29);
    #2;
    i_rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    #1;
    i_rst = 1'b0;
    cmd(0, 0, 0, 0, 0);
    chk("t6_divrst_drop", {7'd0, o_div_rst}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
